// File: rtl/llc_fill_ctrl_pkg.sv
// LLC miss-handling shared definitions.
// Line geometry, fill FSM states and memory command bundle.
package llc_fill_ctrl_pkg;

  localparam int LLC_ADDR_W   = 32;
  localparam int LLC_OFFSET_W = 6;
  localparam int LINE_BYTES   = 1 << LLC_OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_CMD,
    S_WB_FETCH,
    S_WB_SEND,
    S_RD_CMD,
    S_RD_DATA,
    S_DONE
  } fill_state_e;

  typedef struct packed {
    logic                  write;
    logic [LLC_ADDR_W-1:0] addr;
  } mem_cmd_t;

  function automatic logic [LLC_ADDR_W-1:0] line_addr(
    input logic [LLC_ADDR_W-1:0] a
  );
    return {a[LLC_ADDR_W-1:LLC_OFFSET_W], {LLC_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/llc_fill_ctrl.sv
// LLC fill controller: optional victim writeback, then line fetch
// and byte-wise fill into the array over a byte-wide memory bus.
module llc_fill_ctrl
  import llc_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W   = LLC_ADDR_W,
  parameter int OFFSET_W = LLC_OFFSET_W,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                wb_needed,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic                ev_rd_en,
  output logic [OFFSET_W-1:0] ev_rd_offset,
  input  logic [DATA_W-1:0]   ev_rd_data,
  output logic                fill_we,
  output logic [OFFSET_W-1:0] fill_offset,
  output logic [DATA_W-1:0]   fill_data,
  output logic                fill_done,
  output logic [ADDR_W-1:0]   fill_addr,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_cmd_write,
  output logic [ADDR_W-1:0]   mem_cmd_addr,
  output logic                mem_wdata_valid,
  input  logic                mem_wdata_ready,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rdata_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err
);

  localparam logic [OFFSET_W-1:0] LAST = '1;

  fill_state_e         r_state;
  logic [OFFSET_W-1:0] r_beat;
  logic [ADDR_W-1:0]   r_miss_line;
  mem_cmd_t            r_cmd;
  logic [DATA_W-1:0]   r_hold;
  logic                r_miss_ready;
  logic                r_cmd_valid;
  logic                r_ev_rd_en;
  logic                r_wvalid;
  logic                r_fill_we;
  logic [OFFSET_W-1:0] r_fill_offset;
  logic [DATA_W-1:0]   r_fill_data;
  logic                r_fill_done;
  logic [ADDR_W-1:0]   r_fill_addr;
  logic                r_err;
  logic                w_last;

  assign w_last = (r_beat == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_beat        <= '0;
      r_miss_line   <= '0;
      r_cmd         <= '0;
      r_hold        <= '0;
      r_miss_ready  <= 1'b1;
      r_cmd_valid   <= 1'b0;
      r_ev_rd_en    <= 1'b0;
      r_wvalid      <= 1'b0;
      r_fill_we     <= 1'b0;
      r_fill_offset <= '0;
      r_fill_data   <= '0;
      r_fill_done   <= 1'b0;
      r_fill_addr   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_ev_rd_en  <= 1'b0;
      r_fill_we   <= 1'b0;
      r_fill_done <= 1'b0;
      // Read beats are only legal while streaming the fill.
      if (mem_rdata_valid && r_state != S_RD_DATA)
        r_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (miss_valid) begin
            r_miss_line  <= line_addr(miss_addr);
            r_miss_ready <= 1'b0;
            r_cmd_valid  <= 1'b1;
            if (wb_needed) begin
              r_state <= S_WB_CMD;
              r_cmd   <= '{write: 1'b1, addr: line_addr(wb_addr)};
            end else begin
              r_state <= S_RD_CMD;
              r_cmd   <= '{write: 1'b0, addr: line_addr(miss_addr)};
            end
          end
        end
        S_WB_CMD: begin
          if (mem_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_beat      <= '0;
            r_ev_rd_en  <= 1'b1;
            r_state     <= S_WB_FETCH;
          end
        end
        S_WB_FETCH: begin
          r_hold   <= ev_rd_data;
          r_wvalid <= 1'b1;
          r_state  <= S_WB_SEND;
        end
        S_WB_SEND: begin
          if (mem_wdata_ready) begin
            r_wvalid <= 1'b0;
            if (w_last) begin
              r_cmd       <= '{write: 1'b0, addr: r_miss_line};
              r_cmd_valid <= 1'b1;
              r_state     <= S_RD_CMD;
            end else begin
              r_beat     <= r_beat + 1'b1;
              r_ev_rd_en <= 1'b1;
              r_state    <= S_WB_FETCH;
            end
          end
        end
        S_RD_CMD: begin
          if (mem_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_beat      <= '0;
            r_state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (mem_rdata_valid) begin
            r_fill_we     <= 1'b1;
            r_fill_offset <= r_beat;
            r_fill_data   <= mem_rdata;
            if (w_last) begin
              r_fill_done <= 1'b1;
              r_fill_addr <= r_miss_line;
              r_state     <= S_DONE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_fill_addr  <= '0;
          r_beat       <= '0;
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miss_ready      = r_miss_ready;
  assign ev_rd_en        = r_ev_rd_en;
  assign ev_rd_offset    = r_beat;
  assign fill_we         = r_fill_we;
  assign fill_offset     = r_fill_offset;
  assign fill_data       = r_fill_data;
  assign fill_done       = r_fill_done;
  assign fill_addr       = r_fill_addr;
  assign mem_cmd_valid   = r_cmd_valid;
  assign mem_cmd_write   = r_cmd.write;
  assign mem_cmd_addr    = r_cmd.addr;
  assign mem_wdata_valid = r_wvalid;
  assign mem_wdata       = r_hold;
  assign busy            = (r_state != S_IDLE);
  assign err             = r_err;

endmodule

// File: tb/tb_llc_fill_ctrl.sv
// Scoreboard bench for llc_fill_ctrl: memory and array models,
// backpressure, stray beats, reset abort and back-to-back misses.
module tb_llc_fill_ctrl;
  import llc_fill_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        miss_valid, miss_ready, wb_needed;
  logic [31:0] miss_addr, wb_addr;
  logic        ev_rd_en;
  logic [5:0]  ev_rd_offset;
  logic [7:0]  ev_rd_data;
  logic        fill_we, fill_done;
  logic [5:0]  fill_offset;
  logic [7:0]  fill_data;
  logic [31:0] fill_addr;
  logic        mem_cmd_valid, mem_cmd_write;
  logic        mem_cmd_ready = 1'b1;
  logic [31:0] mem_cmd_addr;
  logic        mem_wdata_valid;
  logic        mem_wdata_ready = 1'b1;
  logic [7:0]  mem_wdata;
  logic        mem_rdata_valid;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy, err;

  logic beat_v = 1'b0;
  logic stray_v = 1'b0;
  assign mem_rdata_valid = beat_v | stray_v;
  assign ev_rd_data = {2'b00, ev_rd_offset} ^ 8'hFF;

  llc_fill_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_addr(miss_addr), .wb_needed(wb_needed), .wb_addr(wb_addr),
    .ev_rd_en(ev_rd_en), .ev_rd_offset(ev_rd_offset),
    .ev_rd_data(ev_rd_data),
    .fill_we(fill_we), .fill_offset(fill_offset),
    .fill_data(fill_data), .fill_done(fill_done),
    .fill_addr(fill_addr),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  logic [32:0] q_cmd[$];
  logic [7:0]  q_wd[$];
  logic [13:0] q_fill[$];
  logic [31:0] q_done[$];
  logic [7:0]  q_seed[$];

  int cyc = 0, acc_cyc = 0, done_cyc = 0;
  int n_acc = 0, n_done = 0, n_fill = 0;
  int rd_cnt = 0, stall_cnt = 0, ev_idx = 0;
  int cmd_stall = 0;
  bit wd_toggle = 0, lat_on = 0, b2b_on = 0;
  logic [7:0]  rd_seed = 8'h00, cur_seed = 8'h00;
  bit          cmd_wait = 0, wd_wait = 0;
  logic [32:0] cmd_prev = '0;
  logic [7:0]  wd_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      q_cmd.delete(); q_wd.delete(); q_fill.delete();
      q_done.delete(); q_seed.delete();
      rd_cnt = 0; beat_v = 1'b0; stall_cnt = 0;
      cmd_wait = 0; wd_wait = 0;
    end else begin
      if (fill_we) begin
        n_fill++;
        if (q_fill.size() == 0) check("fill_unexp", 1, 0);
        else check("fill", {fill_offset, fill_data}, q_fill.pop_front());
      end
      if (fill_done) begin
        n_done++;
        done_cyc = cyc;
        check("done_we", fill_we, 1);
        if (q_done.size() == 0) check("done_unexp", 1, 0);
        else check("fill_addr", fill_addr, q_done.pop_front());
        if (lat_on) check("latency", cyc - acc_cyc, 66);
      end
      if (miss_ready) check("ready_idle", busy, 0);
      if (ev_rd_en) begin
        check("ev_off", ev_rd_offset, ev_idx[5:0]);
        ev_idx++;
      end
      // Beats driven here are sampled at the coming posedge.
      if (rd_cnt > 0) begin
        beat_v = 1'b1;
        mem_rdata = cur_seed + 8'(64 - rd_cnt);
        q_fill.push_back({6'(64 - rd_cnt), mem_rdata});
        rd_cnt--;
      end else begin
        beat_v = 1'b0;
      end
      if (cmd_wait)
        check("cmd_hold", {mem_cmd_valid, mem_cmd_write, mem_cmd_addr},
              {1'b1, cmd_prev});
      if (wd_wait)
        check("wd_hold", {mem_wdata_valid, mem_wdata}, {1'b1, wd_prev});
      if (mem_cmd_valid && stall_cnt < cmd_stall) begin
        mem_cmd_ready = 1'b0;
        stall_cnt++;
      end else begin
        mem_cmd_ready = 1'b1;
      end
      if (wd_toggle) mem_wdata_ready = ~mem_wdata_ready;
      else mem_wdata_ready = 1'b1;
      cmd_wait = mem_cmd_valid && !mem_cmd_ready;
      cmd_prev = {mem_cmd_write, mem_cmd_addr};
      wd_wait = mem_wdata_valid && !mem_wdata_ready;
      wd_prev = mem_wdata;
      if (mem_cmd_valid && mem_cmd_ready) begin
        stall_cnt = 0;
        if (q_cmd.size() == 0) check("cmd_unexp", 1, 0);
        else check("cmd", {mem_cmd_write, mem_cmd_addr}, q_cmd.pop_front());
        if (mem_cmd_write) begin
          ev_idx = 0;
        end else begin
          rd_cnt = 64;
          cur_seed = (q_seed.size() != 0) ? q_seed.pop_front() : 8'h00;
        end
      end
      if (mem_wdata_valid && mem_wdata_ready) begin
        if (q_wd.size() == 0) check("wd_unexp", 1, 0);
        else check("wdata", mem_wdata, q_wd.pop_front());
      end
      if (miss_valid && miss_ready) begin
        n_acc++;
        if (b2b_on) check("b2b_gap", cyc - done_cyc, 1);
        acc_cyc = cyc;
        if (wb_needed) begin
          q_cmd.push_back({1'b1, line_addr(wb_addr)});
          for (int i = 0; i < 64; i++) q_wd.push_back(8'(i) ^ 8'hFF);
        end
        q_cmd.push_back({1'b0, line_addr(miss_addr)});
        q_done.push_back(line_addr(miss_addr));
        q_seed.push_back(rd_seed);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int tgt);
    for (int k = 0; k < 200 && n_acc < tgt; k++) tick();
    check("acc_to", n_acc, tgt);
  endtask

  task automatic wait_done(input int tgt);
    for (int k = 0; k < 2000 && n_done < tgt; k++) tick();
    check("done_to", n_done, tgt);
  endtask

  task automatic run_miss(input logic [31:0] ma, input logic wn,
                          input logic [31:0] wa, input logic [7:0] sd);
    int a;
    int d;
    a = n_acc + 1;
    d = n_done + 1;
    rd_seed = sd;
    miss_addr = ma;
    wb_needed = wn;
    wb_addr = wa;
    miss_valid = 1'b1;
    wait_acc(a);
    miss_valid = 1'b0;
    wait_done(d);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check(tag, {miss_ready, busy, mem_cmd_valid, mem_wdata_valid,
                ev_rd_en, fill_we, fill_done, err}, 8'h80);
  endtask

  initial begin
    int a0;
    int d0;
    miss_valid = 1'b0;
    miss_addr = '0;
    wb_needed = 1'b0;
    wb_addr = '0;
    repeat (3) tick();
    check_idle("rst_ctl");
    check("rst_addr", {mem_cmd_addr, fill_addr}, 0);
    check("rst_dat", {mem_cmd_write, fill_offset, fill_data,
                      mem_wdata, ev_rd_offset}, 0);
    reset = 1'b1;
    tick();

    lat_on = 1;
    run_miss(32'h1234_5678, 1'b0, 32'h0, 8'h00);
    lat_on = 0;
    run_miss(32'h0000_1000, 1'b1, 32'hABC0_0007, 8'h40);

    cmd_stall = 5;
    wd_toggle = 1;
    run_miss(32'h5555_5581, 1'b1, 32'h5555_55A3, 8'h80);
    cmd_stall = 0;
    wd_toggle = 0;
    repeat (2) tick();

    // Second request held from the first acceptance onward.
    lat_on = 1;
    a0 = n_acc;
    d0 = n_done;
    rd_seed = 8'h10;
    miss_addr = 32'h0BAD_0040;
    wb_needed = 1'b0;
    miss_valid = 1'b1;
    wait_acc(a0 + 1);
    miss_addr = 32'hCAFE_01C5;
    rd_seed = 8'hA0;
    b2b_on = 1;
    wait_acc(a0 + 2);
    b2b_on = 0;
    miss_valid = 1'b0;
    wait_done(d0 + 2);
    lat_on = 0;
    tick();

    check("err_pre", err, 0);
    stray_v = 1'b1;
    tick();
    stray_v = 1'b0;
    check("err_set", err, 1);
    repeat (5) tick();
    check("err_sticky", err, 1);

    a0 = n_acc;
    d0 = n_done;
    rd_seed = 8'h33;
    miss_addr = 32'h7777_0000;
    wb_needed = 1'b0;
    miss_valid = 1'b1;
    wait_acc(a0 + 1);
    miss_valid = 1'b0;
    a0 = n_fill + 20;
    for (int k = 0; k < 200 && n_fill < a0; k++) tick();
    check("fill20_to", n_fill, a0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("abort_ctl");
    repeat (80) tick();
    check("no_done", n_done, d0);

    run_miss(32'h0123_4567, 1'b1, 32'h0123_4500, 8'h5A);

    check("sb_empty", q_cmd.size() + q_wd.size() + q_fill.size()
          + q_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
